// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM state encoding,
// default sizing, and the fixed master slot assignments.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ           = 3;
    localparam int DEFAULT_TURNAROUND_CYCLES = 1;

    localparam int REQ_CTRL   = 0;
    localparam int REQ_BRIDGE = 1;
    localparam int REQ_DMA    = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr+1 with wrap-around, as one-hot and as an index.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand_idx [N];

    // cand_idx[k] is the master examined at priority position k.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum = {1'b0, ptr} + (IW+1)'(gi + 1);
        assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[cand_idx[k]]) begin
                valid = 1'b1;
                idx   = cand_idx[k];
            end
        end
        onehot = valid ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared bus with turnaround gaps between
// tenures. Define BUS_ARB_TIMEOUT_EN to enable forced revoke of long tenures.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ           = DEFAULT_NUM_REQ,
    parameter int TURNAROUND_CYCLES = DEFAULT_TURNAROUND_CYCLES,
    parameter int HOLD_W            = 8,
    parameter int MAX_HOLD          = 64
) (
    input  logic                       write_clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       busy,
    output logic [HOLD_W-1:0]          hold_count,
    output logic                       timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = 3;
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND_CYCLES - 1);

    arb_state_t         state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [IW-1:0]      owner_id_reg;
    logic [IW-1:0]      ptr_reg;
    logic [HOLD_W-1:0]  hold_count_reg;
    logic [TW-1:0]      turn_cnt_reg;
    logic               timeout_reg;

    logic [NUM_REQ-1:0] elig_req;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               force_revoke;
    logic               arb_point;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [NUM_REQ-1:0] mask_reg;

    // >= so a revoke still fires on the first unlocked edge after the limit passed.
    assign force_revoke = (state_reg == GRANT) && req[owner_id_reg]
                        && !lock[owner_id_reg] && (hold_count_reg >= HOLD_LIMIT);

    // A revoked master stays out of arbitration until it drops its request.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        always_ff @(posedge write_clk or negedge rst_n) begin
            if (!rst_n) begin
                mask_reg[gi] <= 1'b0;
            end else if (force_revoke && (owner_id_reg == IW'(gi))) begin
                mask_reg[gi] <= 1'b1;
            end else if (!req[gi]) begin
                mask_reg[gi] <= 1'b0;
            end
        end
    end

    assign elig_req = req & ~mask_reg;
`else
    localparam int unused_max_hold = MAX_HOLD;
    logic unused_lock;

    assign unused_lock  = ^lock;
    assign force_revoke = 1'b0;
    assign elig_req     = req;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req    (elig_req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign arb_point = (state_reg == IDLE) || ((state_reg == TURN) && (turn_cnt_reg == '0));

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            owner_id_reg   <= '0;
            ptr_reg        <= IW'(NUM_REQ - 1);
            hold_count_reg <= '0;
            turn_cnt_reg   <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            if (arb_point) begin
                if (pick_valid) begin
                    state_reg      <= GRANT;
                    grant_reg      <= pick_onehot;
                    owner_id_reg   <= pick_idx;
                    ptr_reg        <= pick_idx;
                    hold_count_reg <= '0;
                end else begin
                    state_reg <= IDLE;
                end
            end else begin
                case (state_reg)
                    GRANT: begin
                        if (!req[owner_id_reg] || force_revoke) begin
                            state_reg      <= TURN;
                            grant_reg      <= '0;
                            hold_count_reg <= '0;
                            turn_cnt_reg   <= TURN_LOAD;
                            timeout_reg    <= force_revoke;
                        end else if (hold_count_reg != '1) begin
                            hold_count_reg <= hold_count_reg + 1'b1;
                        end
                    end
                    TURN: begin
                        turn_cnt_reg <= turn_cnt_reg - 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = |grant_reg;
    assign owner_id    = owner_id_reg;
    assign busy        = (state_reg != IDLE);
    assign hold_count  = hold_count_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: instance A (turnaround 1, MAX_HOLD 4) and
// instance B (turnaround 3); timeout checks follow BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter;

    logic       clk;
    logic       a_rst_n, b_rst_n;
    logic [2:0] a_req, a_lock, a_grant;
    logic [2:0] b_req, b_lock, b_grant;
    logic       a_gv, a_busy, a_to;
    logic       b_gv, b_busy, b_to;
    logic [1:0] a_owner, b_owner;
    logic [7:0] a_hold, b_hold;

    int n_vec = 0;
    int n_err = 0;
    int to_seen;

    bus_arbiter #(
        .NUM_REQ(3), .TURNAROUND_CYCLES(1), .HOLD_W(8), .MAX_HOLD(4)
    ) dut_a (
        .write_clk(clk), .rst_n(a_rst_n), .req(a_req), .lock(a_lock),
        .grant(a_grant), .grant_valid(a_gv), .owner_id(a_owner), .busy(a_busy),
        .hold_count(a_hold), .timeout(a_to)
    );

    bus_arbiter #(
        .NUM_REQ(3), .TURNAROUND_CYCLES(3), .HOLD_W(8), .MAX_HOLD(64)
    ) dut_b (
        .write_clk(clk), .rst_n(b_rst_n), .req(b_req), .lock(b_lock),
        .grant(b_grant), .grant_valid(b_gv), .owner_id(b_owner), .busy(b_busy),
        .hold_count(b_hold), .timeout(b_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst_n = 1'b0;
        #2;
        a_rst_n = 1'b1;
    endtask

    initial begin
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_req = '0; a_lock = '0; b_req = '0; b_lock = '0;
        #2;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        #1;
        check("rst_grant", a_grant, 0);
        check("rst_gv", a_gv, 0);
        check("rst_busy", a_busy, 0);
        check("rst_hold", a_hold, 0);
        check("rst_timeout", a_to, 0);
        check("rst_owner", a_owner, 0);
        step();
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Single master tenure and release, turnaround 1
        a_req = 3'b001;
        step();
        check("s1_grant", a_grant, 3'b001);
        check("s1_owner", a_owner, 0);
        check("s1_gv", a_gv, 1);
        check("s1_hold0", a_hold, 0);
        step(); step(); step();
        check("s1_hold3", a_hold, 3);
        a_req = 3'b000;
        step();
        check("s1_rel_grant", a_grant, 0);
        check("s1_rel_busy", a_busy, 1);
        check("s1_rel_hold", a_hold, 0);
        step();
        check("s1_idle_busy", a_busy, 0);

        // Turnaround 3 on instance B: master 1 releases while master 2 waits
        b_req = 3'b010;
        step();
        check("s3_grant1", b_grant, 3'b010);
        check("s3_owner1", b_owner, 1);
        b_req = 3'b110;
        step();
        check("s3_hold_grant", b_grant, 3'b010);
        b_req = 3'b100;
        for (int t = 0; t < 3; t++) begin
            step();
            check("s3_gap_grant", b_grant, 0);
            check("s3_gap_busy", b_busy, 1);
        end
        step();
        check("s3_grant2", b_grant, 3'b100);
        check("s3_owner2", b_owner, 2);
        b_req = 3'b000;

        // Round-robin rotation with all three requesting
        reset_a();
        a_req = 3'b111;
        step();
        for (int k = 0; k < 4; k++) begin
            int e;
            logic [2:0] exp_g;
            e = (k == 3) ? 0 : k;
            exp_g = 3'b001 << e;
            check("rr_grant_first", a_grant, exp_g);
            check("rr_onehot", ($countones(a_grant) <= 1), 1);
            step();
            check("rr_grant_second", a_grant, exp_g);
            a_req[e] = 1'b0;
            step();
            check("rr_gap", a_grant, 0);
            a_req[e] = 1'b1;
            step();
        end
        a_req = 3'b000;
        step(); step();

        // Asynchronous reset in the middle of a tenure
        a_req = 3'b010;
        step();
        check("s4_grant", a_grant, 3'b010);
        #1 a_rst_n = 1'b0;
        #1;
        check("s4_async_grant", a_grant, 0);
        check("s4_async_busy", a_busy, 0);
        check("s4_async_owner", a_owner, 0);
        a_req = 3'b111;
        #1 a_rst_n = 1'b1;
        step();
        check("s4_first_grant", a_grant, 3'b001);
        a_req = 3'b000;
        step(); step();

`ifdef BUS_ARB_TIMEOUT_EN
        // Forced revoke after MAX_HOLD granted cycles
        reset_a();
        a_lock = 3'b000;
        a_req  = 3'b011;
        step();
        check("to_grant", a_grant, 3'b001);
        step(); step(); step();
        check("to_before_grant", a_grant, 3'b001);
        check("to_before_pulse", a_to, 0);
        step();
        check("to_revoke_grant", a_grant, 0);
        check("to_pulse", a_to, 1);
        step();
        check("to_next_grant", a_grant, 3'b010);
        check("to_pulse_end", a_to, 0);
        a_req = 3'b001;
        step();
        check("to_turn_grant", a_grant, 0);
        step();
        check("to_masked_grant", a_grant, 0);
        check("to_masked_busy", a_busy, 0);
        step();
        check("to_still_masked", a_grant, 0);
        a_req = 3'b000;
        step();
        a_req = 3'b001;
        step();
        check("to_unmasked_grant", a_grant, 3'b001);
        a_req = 3'b000;
        step(); step();

        // Locked owner never times out; hold count saturates
        reset_a();
        a_lock = 3'b001;
        a_req  = 3'b011;
        step();
        check("lk_grant", a_grant, 3'b001);
        to_seen = 0;
        repeat (300) begin
            step();
            if (a_to) to_seen++;
        end
        check("lk_no_timeout", to_seen, 0);
        check("lk_hold_sat", a_hold, 8'hff);
        check("lk_grant_kept", a_grant, 3'b001);
        a_lock = 3'b000;
        step();
        check("lk_revoke_grant", a_grant, 0);
        check("lk_revoke_pulse", a_to, 1);
        step();
        check("lk_next_grant", a_grant, 3'b010);
        a_req = 3'b000;
`else
        // Without the timeout feature a long tenure is never revoked
        reset_a();
        a_lock = 3'b000;
        a_req  = 3'b011;
        step();
        check("nt_grant", a_grant, 3'b001);
        to_seen = 0;
        repeat (10) begin
            step();
            if (a_to) to_seen++;
        end
        check("nt_no_timeout", to_seen, 0);
        check("nt_grant_kept", a_grant, 3'b001);
        check("nt_hold", a_hold, 10);
        a_req = 3'b000;
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
